audio_path_ctrl: RTL and testbench

- Sequencer between the left-justified codec receiver (ADC side) and transmitter (DAC side); both run on BCLK, which is also `clk`.
- Issues start pulses to each side and detects their data_ready handshakes.
- Buffers captured left/right sample pairs in a small FIFO and feeds them to the transmitter.
- Handles mute, priming, overrun, underrun and handshake timeouts; exposes sticky status for a host.

---
 rtl/audio_path_ctrl.sv | 169 ++++++++++++++++
 tb/tb_audio_path_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_path_ctrl.sv
// Capture/playback sequencer between a left-justified codec receiver and transmitter.
// Captured L/R pairs pass through a small FIFO; sticky status reports overrun, underrun and timeouts.
module audio_path_ctrl #(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 4,
   parameter int PRIME      = 2,
   parameter int TIMEOUT    = 256
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        mute,
   input  logic                        clr_status,
   output logic                        in_start,
   input  logic                        in_data_ready,
   input  logic [DATA_WIDTH-1:0]       in_left,
   input  logic [DATA_WIDTH-1:0]       in_right,
   output logic                        out_start,
   input  logic                        out_data_ready,
   output logic [DATA_WIDTH-1:0]       out_left,
   output logic [DATA_WIDTH-1:0]       out_right,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        busy,
   output logic                        overrun,
   output logic                        underrun,
   output logic                        timeout_err,
   output logic [15:0]                 frame_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {C_IDLE, C_START, C_WAIT} c_state_t;
   typedef enum logic [2:0] {P_IDLE, P_PRIME, P_LOAD, P_START, P_WAIT} p_state_t;

   c_state_t c_state, c_next;
   p_state_t p_state, p_next;

   logic                      in_dr_q, out_dr_q;
   logic                      in_edge, out_edge;
   logic [TW-1:0]             c_timer, p_timer;
   logic                      c_timeout, p_timeout;
   logic [2*DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic [LW-1:0]             level;
   logic                      empty, full, push, pop, push_ok, drop, flush;

   assign in_edge   = in_data_ready & ~in_dr_q;
   assign out_edge  = out_data_ready & ~out_dr_q;
   assign c_timeout = (c_state == C_WAIT) && !in_edge && (c_timer == TW'(TIMEOUT - 1));
   assign p_timeout = (p_state == P_WAIT) && !out_edge && (p_timer == TW'(TIMEOUT - 1));

   assign empty   = (level == '0);
   assign full    = (level == LW'(FIFO_DEPTH));
   assign push    = (c_state == C_WAIT) && in_edge;
   assign pop     = (p_state == P_LOAD) && !empty;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;
   assign flush   = !enable && (c_state == C_IDLE) && (p_state == P_IDLE);

   assign in_start   = (c_state == C_START);
   assign out_start  = (p_state == P_START);
   assign busy       = (c_state != C_IDLE) || (p_state != P_IDLE);
   assign fifo_level = level;

   always_comb begin
      c_next = c_state;
      case (c_state)
         C_IDLE:  if (enable) c_next = C_START;
         C_START: c_next = C_WAIT;
         C_WAIT:  if (in_edge || c_timeout) c_next = enable ? C_START : C_IDLE;
         default: c_next = C_IDLE;
      endcase
   end

   always_comb begin
      p_next = p_state;
      case (p_state)
         P_IDLE:  if (enable) p_next = P_PRIME;
         P_PRIME: begin
            if (!enable)                    p_next = P_IDLE;
            else if (level >= LW'(PRIME))   p_next = P_LOAD;
         end
         P_LOAD:  p_next = P_START;
         P_START: p_next = P_WAIT;
         // A timeout re-sends the pair already held on out_left/out_right.
         P_WAIT: begin
            if (out_edge || p_timeout) begin
               if (!enable)       p_next = P_IDLE;
               else if (out_edge) p_next = P_LOAD;
               else               p_next = P_START;
            end
         end
         default: p_next = P_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_state <= C_IDLE;
         p_state <= P_IDLE;
      end else begin
         c_state <= c_next;
         p_state <= p_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {in_left, in_right};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_dr_q     <= 1'b0;
         out_dr_q    <= 1'b0;
         c_timer     <= '0;
         p_timer     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         out_left    <= '0;
         out_right   <= '0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
         timeout_err <= 1'b0;
         frame_count <= '0;
      end else begin
         in_dr_q  <= in_data_ready;
         out_dr_q <= out_data_ready;

         if (c_state == C_START)     c_timer <= '0;
         else if (c_state == C_WAIT) c_timer <= c_timer + TW'(1);
         if (p_state == P_START)     p_timer <= '0;
         else if (p_state == P_WAIT) p_timer <= p_timer + TW'(1);

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      level <= level + LW'(1);
            else if (pop && !push_ok) level <= level - LW'(1);
         end

         if (p_state == P_LOAD) begin
            if (empty || mute) begin
               out_left  <= '0;
               out_right <= '0;
            end else begin
               {out_left, out_right} <= mem[rd_ptr];
            end
         end

         if (push) frame_count <= frame_count + 16'd1;

         if (drop)            overrun <= 1'b1;
         else if (clr_status) overrun <= 1'b0;
         if ((p_state == P_LOAD) && empty) underrun <= 1'b1;
         else if (clr_status)              underrun <= 1'b0;
         if (c_timeout || p_timeout) timeout_err <= 1'b1;
         else if (clr_status)        timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_path_ctrl.sv
// Directed bench for audio_path_ctrl: a pair queue models the FIFO; expectations are popped
// and compared each time the transmitter start pulse appears.
module tb_audio_path_ctrl;

   localparam int DW    = 24;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n, enable, mute, clr_status;
   logic          in_start, in_data_ready, out_start, out_data_ready;
   logic [DW-1:0] in_left, in_right, out_left, out_right;
   logic [2:0]    fifo_level;
   logic          busy, overrun, underrun, timeout_err;
   logic [15:0]   frame_count;

   logic [2*DW-1:0] exp_q[$];
   logic [2*DW-1:0] first_pair;
   bit              exp_overrun;
   int              exp_frames;
   int              n_checks = 0;
   int              n_fail   = 0;

   audio_path_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRIME(2), .TIMEOUT(256)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mute(mute), .clr_status(clr_status),
      .in_start(in_start), .in_data_ready(in_data_ready), .in_left(in_left), .in_right(in_right),
      .out_start(out_start), .out_data_ready(out_data_ready), .out_left(out_left),
      .out_right(out_right), .fifo_level(fifo_level), .busy(busy), .overrun(overrun),
      .underrun(underrun), .timeout_err(timeout_err), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the capture FSM in its first C_WAIT cycle.
   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b1; mute = 1'b0; clr_status = 1'b0;
      in_data_ready = 1'b0; out_data_ready = 1'b0; in_left = '0; in_right = '0;
      tick(3);
      rst_n = 1'b1;
      exp_q.delete();
      exp_overrun = 1'b0;
      exp_frames  = 0;
      tick(2);
   endtask

   // Precondition: capture FSM in C_WAIT. Returns with it back in C_WAIT (when enabled).
   task automatic capture(input logic [DW-1:0] l, input logic [DW-1:0] r,
                          input bit clr, input bit exp_restart);
      in_left = l; in_right = r; in_data_ready = 1'b1; clr_status = clr;
      exp_frames++;
      if (exp_q.size() < DEPTH) begin
         exp_q.push_back({l, r});
         if (clr) exp_overrun = 1'b0;
      end else begin
         exp_overrun = 1'b1;
      end
      @(negedge clk);
      in_data_ready = 1'b0; clr_status = 1'b0;
      check("in_start_after_edge", 48'(in_start), 48'(exp_restart));
      @(negedge clk);
   endtask

   task automatic wait_out_start();
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (out_start) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("out_start_seen", 48'(seen), 48'(1));
   endtask

   task automatic check_frame(input string tag);
      logic [2*DW-1:0] exp;
      wait_out_start();
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         if (mute) exp = '0;
      end else begin
         exp = '0;
      end
      check({tag, "_left"},  48'(out_left),   48'(exp[2*DW-1:DW]));
      check({tag, "_right"}, 48'(out_right),  48'(exp[DW-1:0]));
      check({tag, "_level"}, 48'(fifo_level), 48'(exp_q.size()));
   endtask

   // Precondition: at the out_start cycle. Returns in the following P_LOAD cycle.
   task automatic ack();
      @(negedge clk);
      out_data_ready = 1'b1;
      @(negedge clk);
      out_data_ready = 1'b0;
   endtask

   initial begin
      // Reset: outputs quiet even with enable held high, then a single start pulse.
      rst_n = 1'b0; enable = 1'b1; mute = 1'b0; clr_status = 1'b0;
      in_data_ready = 1'b0; out_data_ready = 1'b0; in_left = '0; in_right = '0;
      tick(3);
      check("rst_in_start",  48'(in_start),    48'(0));
      check("rst_out_start", 48'(out_start),   48'(0));
      check("rst_out_left",  48'(out_left),    48'(0));
      check("rst_out_right", 48'(out_right),   48'(0));
      check("rst_level",     48'(fifo_level),  48'(0));
      check("rst_busy",      48'(busy),        48'(0));
      check("rst_overrun",   48'(overrun),     48'(0));
      check("rst_underrun",  48'(underrun),    48'(0));
      check("rst_timeout",   48'(timeout_err), 48'(0));
      check("rst_frames",    48'(frame_count), 48'(0));
      rst_n = 1'b1;
      tick(1);
      check("rel_in_start_hi", 48'(in_start), 48'(1));
      check("rel_busy",        48'(busy),     48'(1));
      tick(1);
      check("rel_in_start_lo", 48'(in_start), 48'(0));

      // Passthrough with priming at two pairs.
      do_reset();
      capture(24'h123456, 24'hABCDEF, 1'b0, 1'b1);
      check("t2_no_early_start", 48'(out_start),  48'(0));
      check("t2_level1",         48'(fifo_level), 48'(1));
      capture(24'h000001, 24'hFFFFFF, 1'b0, 1'b1);
      check_frame("t2_f1");
      check("t2_frames", 48'(frame_count), 48'(exp_frames));
      ack();
      check_frame("t2_f2");
      check("t2_overrun",  48'(overrun),     48'(0));
      check("t2_underrun", 48'(underrun),    48'(0));
      check("t2_timeout",  48'(timeout_err), 48'(0));

      // Overrun with the transmitter stalled, then retry, clear, and set-beats-clear.
      do_reset();
      first_pair = {24'h0A0001, 24'h0B0001};
      capture(24'h0A0001, 24'h0B0001, 1'b0, 1'b1);
      capture(24'h0A0002, 24'h0B0002, 1'b0, 1'b1);
      check_frame("t3_f1");
      for (int k = 3; k <= 6; k++)
         capture(24'h0A0000 + 24'(k), 24'h0B0000 + 24'(k), 1'b0, 1'b1);
      check("t3_level_full", 48'(fifo_level),  48'(DEPTH));
      check("t3_frames",     48'(frame_count), 48'(exp_frames));
      check("t3_overrun",    48'(overrun),     48'(exp_overrun));
      check("t3_no_timeout", 48'(timeout_err), 48'(0));
      wait_out_start();
      check("t3_timeout",     48'(timeout_err), 48'(1));
      check("t3_resend_left", 48'(out_left),    48'(first_pair[2*DW-1:DW]));
      check("t3_resend_right",48'(out_right),   48'(first_pair[DW-1:0]));
      check("t3_level_hold",  48'(fifo_level),  48'(DEPTH));
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      exp_overrun = 1'b0;
      check("t3_clr_overrun", 48'(overrun),     48'(exp_overrun));
      check("t3_clr_timeout", 48'(timeout_err), 48'(0));
      capture(24'h0A0007, 24'h0B0007, 1'b1, 1'b1);
      check("t3_set_wins", 48'(overrun),     48'(exp_overrun));
      check("t3_frames7",  48'(frame_count), 48'(exp_frames));

      // Underrun once the FIFO drains, then mute while it still drains.
      do_reset();
      capture(24'h111111, 24'h222222, 1'b0, 1'b1);
      capture(24'h333333, 24'h444444, 1'b0, 1'b1);
      check_frame("t4_a");
      ack();
      check_frame("t4_b");
      check("t4_no_underrun", 48'(underrun), 48'(0));
      ack();
      check_frame("t4_empty");
      check("t4_underrun", 48'(underrun), 48'(1));
      capture(24'h555555, 24'h666666, 1'b0, 1'b1);
      capture(24'h777777, 24'h888888, 1'b0, 1'b1);
      mute = 1'b1;
      ack();
      check_frame("t4_muted");
      mute = 1'b0;
      ack();
      check_frame("t4_unmuted");
      check("t4_underrun_sticky", 48'(underrun), 48'(1));

      // Capture handshake timeout and retry.
      rst_n = 1'b0; enable = 1'b1;
      tick(3);
      rst_n = 1'b1;
      exp_q.delete();
      tick(1);
      check("t5_in_start", 48'(in_start), 48'(1));
      tick(256);
      check("t5_before_timeout",  48'(timeout_err), 48'(0));
      check("t5_no_start_yet",    48'(in_start),    48'(0));
      tick(1);
      check("t5_timeout",         48'(timeout_err), 48'(1));
      check("t5_retry_start",     48'(in_start),    48'(1));
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      check("t5_cleared", 48'(timeout_err), 48'(0));

      // Enable dropped mid-frame: pending edge captured, then idle and flushed.
      do_reset();
      capture(24'hC0FFEE, 24'hBEEF00, 1'b0, 1'b1);
      enable = 1'b0;
      capture(24'hDEAD01, 24'hDEAD02, 1'b0, 1'b0);
      exp_q.delete();
      check("t6_frames", 48'(frame_count), 48'(exp_frames));
      check("t6_flush",  48'(fifo_level),  48'(exp_q.size()));
      check("t6_busy",   48'(busy),        48'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
